// File: rtl/pio_pkg.sv
// Shared definitions for the PIO host interface: host action codes and default sizing.
// Imported by the host interface top and its FIFO.
package pio_pkg;

  localparam int NUM_SM_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int IMEM_WORDS     = 32;

  localparam logic [31:0] CLKDIV_RST = 32'h0001_0000;

  typedef enum logic [3:0] {
    ACT_NOP       = 4'd0,
    ACT_IMEM      = 4'd1,
    ACT_ENABLE    = 4'd2,
    ACT_PULL      = 4'd3,
    ACT_PUSH      = 4'd4,
    ACT_CLKDIV    = 4'd5,
    ACT_PINCTRL   = 4'd6,
    ACT_EXECCTRL  = 4'd7,
    ACT_SHIFTCTRL = 4'd8,
    ACT_RESTART   = 4'd9
  } pio_action_e;

endpackage

// File: rtl/pio_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
// A pop on a full FIFO frees the slot for a same-cycle push; a pop on empty is ignored.
module pio_fifo
  import pio_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_wptr_nxt;
  logic [AW:0]      w_rptr_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok   = i_pop & ~r_empty;
  assign w_push_ok  = i_push & (~r_full | w_pop_ok);
  assign w_wptr_nxt = w_push_ok ? r_wptr + {{AW{1'b0}}, 1'b1} : r_wptr;
  assign w_rptr_nxt = w_pop_ok  ? r_rptr + {{AW{1'b0}}, 1'b1} : r_rptr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      // Flags are registered from the next pointers so they track the pointers exactly.
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/pio_host_if.sv
// Host-side register and FIFO interface for a bank of PIO state machines.
// Holds the shared instruction memory, per-machine config, enables and TX/RX FIFOs.
module pio_host_if
  import pio_pkg::*;
#(
  parameter int NUM_SM     = NUM_SM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [1:0]            mindex,
  input  logic [4:0]            index,
  input  logic [3:0]            action,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic [NUM_SM-1:0]     tx_full,
  output logic [NUM_SM-1:0]     rx_empty,
  input  logic [5*NUM_SM-1:0]   imem_raddr,
  output logic [16*NUM_SM-1:0]  imem_rdata,
  output logic [32*NUM_SM-1:0]  cfg_clkdiv,
  output logic [32*NUM_SM-1:0]  cfg_pinctrl,
  output logic [32*NUM_SM-1:0]  cfg_execctrl,
  output logic [32*NUM_SM-1:0]  cfg_shiftctrl,
  output logic [NUM_SM-1:0]     sm_en,
  output logic [NUM_SM-1:0]     sm_restart,
  input  logic [NUM_SM-1:0]     sm_pull,
  output logic [32*NUM_SM-1:0]  sm_tx_data,
  output logic [NUM_SM-1:0]     sm_tx_empty,
  input  logic [NUM_SM-1:0]     sm_push,
  input  logic [32*NUM_SM-1:0]  sm_rx_data,
  output logic [NUM_SM-1:0]     sm_rx_full
);

  logic [15:0]                 r_imem [IMEM_WORDS];
  logic [NUM_SM-1:0][31:0]     r_clkdiv;
  logic [NUM_SM-1:0][31:0]     r_pinctrl;
  logic [NUM_SM-1:0][31:0]     r_execctrl;
  logic [NUM_SM-1:0][31:0]     r_shiftctrl;
  logic [NUM_SM-1:0]           r_en;
  logic [NUM_SM-1:0]           r_restart;
  logic [31:0]                 r_dout;

  logic [NUM_SM-1:0][31:0]     w_tx_data;
  logic [NUM_SM-1:0][31:0]     w_rx_data;
  logic [NUM_SM-1:0]           w_tx_full;
  logic [NUM_SM-1:0]           w_tx_empty;
  logic [NUM_SM-1:0]           w_rx_full;
  logic [NUM_SM-1:0]           w_rx_empty;

  // Instruction memory is deliberately left out of reset so programs survive a reset.
  always_ff @(posedge clk) begin
    if (action == ACT_IMEM) r_imem[index] <= din[15:0];
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_clkdiv    <= {NUM_SM{CLKDIV_RST}};
      r_pinctrl   <= '0;
      r_execctrl  <= '0;
      r_shiftctrl <= '0;
      r_en        <= '0;
      r_restart   <= '0;
      r_dout      <= '0;
    end else begin
      r_restart <= (action == ACT_RESTART) ? din[NUM_SM-1:0] : '0;
      if (action == ACT_PULL && !w_rx_empty[mindex]) r_dout <= w_rx_data[mindex];
      case (action)
        ACT_ENABLE:    r_en                <= din[NUM_SM-1:0];
        ACT_CLKDIV:    r_clkdiv[mindex]    <= din;
        ACT_PINCTRL:   r_pinctrl[mindex]   <= din;
        ACT_EXECCTRL:  r_execctrl[mindex]  <= din;
        ACT_SHIFTCTRL: r_shiftctrl[mindex] <= din;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    logic w_sel;
    assign w_sel = (mindex == 2'(g));

    assign imem_rdata[16*g +: 16] = r_imem[imem_raddr[5*g +: 5]];

    pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx (
      .clk     (clk),
      .n_reset (n_reset),
      .i_push  ((action == ACT_PUSH) && w_sel),
      .i_wdata (din),
      .i_pop   (sm_pull[g]),
      .o_rdata (w_tx_data[g]),
      .o_full  (w_tx_full[g]),
      .o_empty (w_tx_empty[g])
    );

    pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx (
      .clk     (clk),
      .n_reset (n_reset),
      .i_push  (sm_push[g]),
      .i_wdata (sm_rx_data[32*g +: 32]),
      .i_pop   ((action == ACT_PULL) && w_sel),
      .o_rdata (w_rx_data[g]),
      .o_full  (w_rx_full[g]),
      .o_empty (w_rx_empty[g])
    );
  end

  assign dout          = r_dout;
  assign tx_full       = w_tx_full;
  assign rx_empty      = w_rx_empty;
  assign sm_tx_data    = w_tx_data;
  assign sm_tx_empty   = w_tx_empty;
  assign sm_rx_full    = w_rx_full;
  assign cfg_clkdiv    = r_clkdiv;
  assign cfg_pinctrl   = r_pinctrl;
  assign cfg_execctrl  = r_execctrl;
  assign cfg_shiftctrl = r_shiftctrl;
  assign sm_en         = r_en;
  assign sm_restart    = r_restart;

endmodule

// File: tb/tb_pio_host_if.sv
// Bench for pio_host_if: reset checks, a config vector table, directed FIFO/imem sequences
// and a randomized run compared against a queue-based reference model.
module tb_pio_host_if;

  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [1:0]    mindex = '0;
  logic [4:0]    index = '0;
  logic [3:0]    action = '0;
  logic [31:0]   din = '0;
  logic [31:0]   dout;
  logic [N-1:0]  tx_full, rx_empty, sm_en, sm_restart, sm_tx_empty, sm_rx_full;
  logic [5*N-1:0]  imem_raddr = '0;
  logic [16*N-1:0] imem_rdata;
  logic [32*N-1:0] cfg_clkdiv, cfg_pinctrl, cfg_execctrl, cfg_shiftctrl;
  logic [N-1:0]    sm_pull = '0;
  logic [N-1:0]    sm_push = '0;
  logic [32*N-1:0] sm_tx_data;
  logic [32*N-1:0] sm_rx_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pio_host_if #(.NUM_SM(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .n_reset(n_reset), .mindex(mindex), .index(index), .action(action),
    .din(din), .dout(dout), .tx_full(tx_full), .rx_empty(rx_empty),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .cfg_clkdiv(cfg_clkdiv), .cfg_pinctrl(cfg_pinctrl), .cfg_execctrl(cfg_execctrl),
    .cfg_shiftctrl(cfg_shiftctrl), .sm_en(sm_en), .sm_restart(sm_restart),
    .sm_pull(sm_pull), .sm_tx_data(sm_tx_data), .sm_tx_empty(sm_tx_empty),
    .sm_push(sm_push), .sm_rx_data(sm_rx_data), .sm_rx_full(sm_rx_full)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [1:0] mi, input logic [31:0] d);
    action = a;
    mindex = mi;
    din    = d;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_tx [N][$];
  logic [31:0] m_rx [N][$];
  logic [15:0] m_imem [32];
  logic [31:0] m_clk [N];
  logic [31:0] m_pin [N];
  logic [31:0] m_exe [N];
  logic [31:0] m_shf [N];
  logic [N-1:0] m_en, m_rst;
  logic [31:0]  m_dout;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tx[i].delete();
      m_rx[i].delete();
      m_clk[i] = 32'h0001_0000;
      m_pin[i] = '0;
      m_exe[i] = '0;
      m_shf[i] = '0;
    end
    m_en   = '0;
    m_rst  = '0;
    m_dout = '0;
  endtask

  task automatic model_edge();
    bit tpop, tpush, rpop, rpush;
    m_rst = (action == 4'd9) ? din[N-1:0] : '0;
    case (action)
      4'd1: m_imem[index] = din[15:0];
      4'd2: m_en = din[N-1:0];
      4'd5: m_clk[mindex] = din;
      4'd6: m_pin[mindex] = din;
      4'd7: m_exe[mindex] = din;
      4'd8: m_shf[mindex] = din;
      default: ;
    endcase
    for (int i = 0; i < N; i++) begin
      tpop  = sm_pull[i] && (m_tx[i].size() > 0);
      tpush = (action == 4'd4) && (int'(mindex) == i) && ((m_tx[i].size() < D) || tpop);
      if (tpop)  void'(m_tx[i].pop_front());
      if (tpush) m_tx[i].push_back(din);
      rpop  = (action == 4'd3) && (int'(mindex) == i) && (m_rx[i].size() > 0);
      rpush = sm_push[i] && ((m_rx[i].size() < D) || rpop);
      if (rpop)  m_dout = m_rx[i].pop_front();
      if (rpush) m_rx[i].push_back(sm_rx_data[32*i +: 32]);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_txf, e_rxe, e_txe, e_rxf;
    logic [32*N-1:0] e_clk, e_pin, e_exe, e_shf;
    for (int i = 0; i < N; i++) begin
      e_txf[i] = (m_tx[i].size() == D);
      e_txe[i] = (m_tx[i].size() == 0);
      e_rxf[i] = (m_rx[i].size() == D);
      e_rxe[i] = (m_rx[i].size() == 0);
      e_clk[32*i +: 32] = m_clk[i];
      e_pin[32*i +: 32] = m_pin[i];
      e_exe[32*i +: 32] = m_exe[i];
      e_shf[32*i +: 32] = m_shf[i];
      if (m_tx[i].size() > 0)
        check($sformatf("tx_head%0d", i), 128'(sm_tx_data[32*i +: 32]), 128'(m_tx[i][0]));
      check($sformatf("imem_rd%0d", i), 128'(imem_rdata[16*i +: 16]),
            128'(m_imem[imem_raddr[5*i +: 5]]));
    end
    check("tx_full", 128'(tx_full), 128'(e_txf));
    check("rx_empty", 128'(rx_empty), 128'(e_rxe));
    check("sm_tx_empty", 128'(sm_tx_empty), 128'(e_txe));
    check("sm_rx_full", 128'(sm_rx_full), 128'(e_rxf));
    check("dout", 128'(dout), 128'(m_dout));
    check("sm_en", 128'(sm_en), 128'(m_en));
    check("sm_restart", 128'(sm_restart), 128'(m_rst));
    check("cfg_clkdiv", 128'(cfg_clkdiv), 128'(e_clk));
    check("cfg_pinctrl", 128'(cfg_pinctrl), 128'(e_pin));
    check("cfg_execctrl", 128'(cfg_execctrl), 128'(e_exe));
    check("cfg_shiftctrl", 128'(cfg_shiftctrl), 128'(e_shf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_inputs(input int cyc);
    int ph, r, tp, sp;
    ph = (cyc / 200) % 2;
    tp = ph ? 16 : 1;
    sp = ph ? 1 : 16;
    for (int i = 0; i < N; i++) begin
      sm_pull[i] = ($urandom_range(0, 19) < tp);
      sm_push[i] = ($urandom_range(0, 19) < sp);
    end
    r = $urandom_range(0, 19);
    if (r < (ph ? 3 : 8))  action = 4'd4;
    else if (r < 13)       action = 4'd3;
    else                   action = 4'($urandom_range(0, 15));
    mindex     = 2'($urandom_range(0, 3));
    index      = 5'($urandom_range(0, 31));
    din        = $urandom;
    imem_raddr = 20'($urandom);
    sm_rx_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- config vector table ----------------
  typedef struct {
    logic [3:0]  act;
    logic [1:0]  mi;
    logic [31:0] din;
    int          sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] get_sel(input int sel, input int mi);
    case (sel)
      0: return cfg_clkdiv[32*mi +: 32];
      1: return cfg_pinctrl[32*mi +: 32];
      2: return cfg_execctrl[32*mi +: 32];
      3: return cfg_shiftctrl[32*mi +: 32];
      4: return 32'(sm_en);
      default: return 32'(sm_restart);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'd0,  2'd1, 32'h0000_0000, 0, 32'h0001_0000};
    vecs[1]  = '{4'd5,  2'd2, 32'h1234_5678, 0, 32'h1234_5678};
    vecs[2]  = '{4'd6,  2'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[3]  = '{4'd7,  2'd3, 32'h0000_1F00, 2, 32'h0000_1F00};
    vecs[4]  = '{4'd8,  2'd1, 32'hC000_0000, 3, 32'hC000_0000};
    vecs[5]  = '{4'd2,  2'd3, 32'hFFFF_FFF5, 4, 32'h0000_0005};
    vecs[6]  = '{4'd9,  2'd0, 32'h0000_0005, 5, 32'h0000_0005};
    vecs[7]  = '{4'd0,  2'd0, 32'h0000_0000, 5, 32'h0000_0000};
    vecs[8]  = '{4'd12, 2'd2, 32'hFFFF_FFFF, 0, 32'h1234_5678};
    vecs[9]  = '{4'd5,  2'd0, 32'h0000_0000, 0, 32'h0000_0000};
    vecs[10] = '{4'd2,  2'd0, 32'h0000_0000, 4, 32'h0000_0000};

    // reset values, sampled while reset is held
    #12;
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_sm_en", 128'(sm_en), 128'(0));
    check("rst_restart", 128'(sm_restart), 128'(0));
    check("rst_tx_full", 128'(tx_full), 128'(0));
    check("rst_rx_empty", 128'(rx_empty), 128'(4'hF));
    check("rst_sm_tx_empty", 128'(sm_tx_empty), 128'(4'hF));
    check("rst_sm_rx_full", 128'(sm_rx_full), 128'(0));
    check("rst_clkdiv", 128'(cfg_clkdiv), {4{32'h0001_0000}});
    check("rst_pinctrl", 128'(cfg_pinctrl), 128'(0));
    check("rst_execctrl", 128'(cfg_execctrl), 128'(0));
    check("rst_shiftctrl", 128'(cfg_shiftctrl), 128'(0));
    n_reset = 1'b1;
    tick();

    foreach (vecs[v]) begin
      drive(vecs[v].act, vecs[v].mi, vecs[v].din);
      tick();
      check($sformatf("vec%0d", v), 128'(get_sel(vecs[v].sel, int'(vecs[v].mi))),
            128'(vecs[v].exp));
    end
    drive(4'd0, 2'd0, 32'h0);

    // imem write then combinational read
    index = 5'd4;
    imem_raddr[4:0] = 5'd4;
    drive(4'd1, 2'd0, 32'hABCD_E081);
    tick();
    drive(4'd0, 2'd0, 32'h0);
    check("imem_e081", 128'(imem_rdata[15:0]), 128'(16'hE081));

    // TX overflow on machine 1, then drain in order
    for (int k = 1; k <= 5; k++) begin
      drive(4'd4, 2'd1, 32'(k));
      tick();
      check($sformatf("tx1_full_after%0d", k), 128'(tx_full[1]), 128'(k >= 4));
    end
    drive(4'd0, 2'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("tx1_head%0d", k), 128'(sm_tx_data[63:32]), 128'(k));
      sm_pull[1] = 1'b1;
      tick();
    end
    sm_pull[1] = 1'b0;
    check("tx1_empty", 128'(sm_tx_empty[1]), 128'(1));
    check("tx1_not_full", 128'(tx_full[1]), 128'(0));

    // RX single word to host
    sm_push[0] = 1'b1;
    sm_rx_data[31:0] = 32'hA5;
    tick();
    sm_push[0] = 1'b0;
    check("rx0_not_empty", 128'(rx_empty[0]), 128'(0));
    drive(4'd3, 2'd0, 32'h0);
    tick();
    drive(4'd0, 2'd0, 32'h0);
    check("rx0_dout", 128'(dout), 128'(32'hA5));
    check("rx0_empty", 128'(rx_empty[0]), 128'(1));
    drive(4'd3, 2'd0, 32'h0);
    tick();
    drive(4'd0, 2'd0, 32'h0);
    check("rx0_pull_empty_dout", 128'(dout), 128'(32'hA5));

    // full RX FIFO 2 with simultaneous push and pull
    for (int k = 0; k < 4; k++) begin
      sm_push[2] = 1'b1;
      sm_rx_data[95:64] = 32'h200 + 32'(k);
      tick();
    end
    sm_push[2] = 1'b0;
    check("rx2_full", 128'(sm_rx_full[2]), 128'(1));
    sm_push[2] = 1'b1;
    sm_rx_data[95:64] = 32'h2FF;
    drive(4'd3, 2'd2, 32'h0);
    tick();
    sm_push[2] = 1'b0;
    check("rx2_both_dout", 128'(dout), 128'(32'h200));
    check("rx2_both_full", 128'(sm_rx_full[2]), 128'(1));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rx2_drain%0d", k), 128'(dout), 128'(k == 4 ? 32'h2FF : 32'h200 + 32'(k)));
    end
    drive(4'd0, 2'd0, 32'h0);
    check("rx2_empty", 128'(rx_empty[2]), 128'(1));

    // async reset with FIFOs partly full
    drive(4'd4, 2'd3, 32'h31);
    tick();
    drive(4'd4, 2'd3, 32'h32);
    sm_push[1] = 1'b1;
    sm_rx_data[63:32] = 32'h77;
    tick();
    sm_push[1] = 1'b0;
    drive(4'd2, 2'd0, 32'hF);
    tick();
    drive(4'd0, 2'd0, 32'h0);
    check("pre_rst_tx3", 128'(sm_tx_empty[3]), 128'(0));
    check("pre_rst_rx1", 128'(rx_empty[1]), 128'(0));
    check("pre_rst_en", 128'(sm_en), 128'(4'hF));
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_rst_tx_full", 128'(tx_full), 128'(0));
    check("mid_rst_rx_empty", 128'(rx_empty), 128'(4'hF));
    check("mid_rst_sm_tx_empty", 128'(sm_tx_empty), 128'(4'hF));
    check("mid_rst_sm_rx_full", 128'(sm_rx_full), 128'(0));
    check("mid_rst_en", 128'(sm_en), 128'(0));
    check("mid_rst_dout", 128'(dout), 128'(0));
    check("mid_rst_imem", 128'(imem_rdata[15:0]), 128'(16'hE081));

    // randomized run against the model
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    model_reset();
    for (int k = 0; k < 32; k++) begin
      action = 4'd1;
      index  = 5'(k);
      din    = $urandom;
      mindex = 2'($urandom_range(0, 3));
      imem_raddr = {4{5'(k)}};
      step();
    end
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(c);
      step();
      if (c == 1500) begin
        #2;
        n_reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #2;
        n_reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_host_if.md
PIO_HOST_IF -- requirements
Module: pio_host_if

Interface
REQ-001 Parameter NUM_SM, 4, number of state machines served.
REQ-002 Parameter FIFO_DEPTH, 4, entries per TX and RX FIFO, power of two.
REQ-003 Port clk  in  1  single clock; reset is asynchronous and active-low.
REQ-004 Port n_reset  in  1  asynchronous active-low reset.
REQ-005 Port mindex  in  2  target machine of the current action.
REQ-006 Port index  in  5  instruction-memory address for action 1.
REQ-007 Port action  in  4  host command: 0 NOP, 1 IMEM write, 2 ENABLE mask, 3 PULL, 4 PUSH, 5 CLKDIV, 6 PINCTRL, 7 EXECCTRL, 8 SHIFTCTRL, 9 RESTART; 10-15 are NOP.
REQ-008 Port din  in  32  host write data.
REQ-009 Port dout  out  32  host read data, loaded by PULL.
REQ-010 Port tx_full  out  NUM_SM  per-machine TX FIFO full.
REQ-011 Port rx_empty  out  NUM_SM  per-machine RX FIFO empty.
REQ-012 Port imem_raddr  in  5*NUM_SM  per-machine instruction fetch address.
REQ-013 Port imem_rdata  out  16*NUM_SM  per-machine instruction, combinational read.
REQ-014 Port cfg_clkdiv, cfg_pinctrl, cfg_execctrl, cfg_shiftctrl  out  32*NUM_SM each  per-machine configuration registers.
REQ-015 Port sm_en  out  NUM_SM  machine enable; sm_restart  out  NUM_SM  one-cycle restart pulses.
REQ-016 Port sm_pull  in  NUM_SM  machine pops its TX FIFO; sm_tx_data  out  32*NUM_SM  TX head; sm_tx_empty  out  NUM_SM.
REQ-017 Port sm_push  in  NUM_SM  machine writes its RX FIFO; sm_rx_data  in  32*NUM_SM; sm_rx_full  out  NUM_SM.

Function
REQ-018 Every action is sampled on a single clk edge; the host holds no handshake, so an action held N cycles executes N times.
REQ-019 Action 1 writes din[15:0] to imem[index]; the new word is visible on imem_rdata the next cycle; imem is shared by all machines.
REQ-020 Action 2 loads sm_en from din[NUM_SM-1:0]; mindex is ignored.
REQ-021 Actions 5-8 load din into the selected register of machine mindex.
REQ-022 Action 9 pulses sm_restart[din[NUM_SM-1:0]] high for exactly one cycle.
REQ-023 Action 4 writes din into the TX FIFO of machine mindex; when that FIFO is full and sm_pull is not asserted the same cycle, the write is dropped with no state change.
REQ-024 Action 3 pops the RX FIFO of machine mindex into dout one cycle later; dout holds its value until the next accepted PULL; PULL on empty leaves dout and the FIFO unchanged.
REQ-025 sm_pull on an empty TX FIFO and sm_push on a full RX FIFO are ignored.
REQ-026 Simultaneous push and pop on one FIFO: when full, both take effect and occupancy stays FIFO_DEPTH; when empty, the push is accepted and the pop is ignored.
REQ-027 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full when MSBs differ and the rest match; empty when equal.
REQ-028 Flags (tx_full, rx_empty, sm_tx_empty, sm_rx_full) are registered views of the pointers and reflect an operation one cycle after it.
REQ-029 Data order through each FIFO is strict first-in first-out.

Reset
REQ-030 While n_reset is low: dout=0, all cfg registers=0 except cfg_clkdiv=32'h0001_0000, sm_en=0, sm_restart=0, all FIFOs empty (tx_full=0, rx_empty=all ones, sm_tx_empty=all ones, sm_rx_full=0).
REQ-031 imem contents are not reset; reset asserted mid-operation discards all FIFO contents and pending restart pulses.

Structure
REQ-032 Action codes, NUM_SM and FIFO_DEPTH defaults live in shared package pio_pkg.
REQ-033 One sub-module, pio_fifo (32-bit synchronous FIFO with push, pop, full and empty), is instantiated 2*NUM_SM times.

Verification
REQ-034 Write imem[4]=16'hE081 with action 1 and drive imem_raddr[0]=4 -> imem_rdata[15:0]=16'hE081 the next cycle.
REQ-035 Issue 5 PUSHes of 1..5 to machine 1 -> tx_full[1]=1 after the 4th; 5 is dropped; sm_pull[1] x4 yields 1,2,3,4, then sm_tx_empty[1]=1.
REQ-036 sm_push[0] with sm_rx_data=32'hA5 followed by PULL on mindex 0 -> dout=32'hA5, rx_empty[0]=1.
REQ-037 Fill RX FIFO 2, then issue sm_push and PULL in the same cycle -> occupancy stays 4 and the oldest word appears on dout.
REQ-038 Action 9 with din=4'b0101 -> sm_restart=4'b0101 for exactly one cycle, then 0.
REQ-039 Assert n_reset low with FIFOs partly full -> all flags return to their reset values immediately and imem is preserved.
